dense2_bias_seq_ctrl: RTL and testbench

Sequencer for the Dense-2 (128->9) output stage. Accepts one accumulated dot-product per output neuron from the MAC engine and addresses the Dense-2 bias ROM for that neuron. It adds the scaled bias, rounds, shifts and saturates the result to int8, then streams it out. It also tracks the argmax across all 9 neurons and reports the predicted wafer-defect class index at the end of each inference.

---
 rtl/dense2_pkg.sv | 22 ++
 rtl/dense2_bias_seq_ctrl_if.sv | 29 ++
 rtl/dense_requant_sat.sv | 43 ++++
 rtl/dense2_bias_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_dense2_bias_seq_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dense2_pkg.sv
// Shared constants and FSM state type for the Dense-2 (128->9) output stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dense2_pkg;

  localparam int NUM_OUT = 9;   // output neurons per inference, bias ROM depth
  localparam int ADDR_W  = 4;   // bias ROM / neuron index width
  localparam int ACC_W   = 24;  // signed MAC accumulator width
  localparam int BIAS_W  = 8;   // signed bias width

  localparam logic signed [7:0] INT8_MIN = 8'sh80;
  localparam logic signed [7:0] INT8_MAX = 8'sh7f;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACC,
    CALC,
    OUT,
    FIN
  } state_t;

endpackage

// File: rtl/dense2_bias_seq_ctrl_if.sv
// Accumulator-in and requantized-out streams of the Dense-2 sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both streams.
// master = controller side (drives acc_ready and the out_* stream),
// slave  = surrounding logic (MAC engine and downstream consumer).
interface dense2_bias_seq_ctrl_if;
  import dense2_pkg::*;

  logic                     acc_valid;
  logic                     acc_ready;
  logic signed [ACC_W-1:0]  acc_data;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [7:0]        out_data;
  logic [ADDR_W-1:0]        out_idx;
  logic                     out_last;

  modport master (
    input  acc_valid, acc_data, out_ready,
    output acc_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    output acc_valid, acc_data, out_ready,
    input  acc_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/dense_requant_sat.sv
// Round-half-up arithmetic right shift by OUT_SHIFT, then saturate to int8.
// Latency: combinational.
// Backpressure: none (pure function of sum_in).
// Ports: sum_in (signed IN_W) -> sat_out (signed int8).
module dense_requant_sat
  import dense2_pkg::*;
#(
  parameter int IN_W      = 30,
  parameter int OUT_SHIFT = 6
) (
  input  logic signed [IN_W-1:0] sum_in,
  output logic signed [7:0]      sat_out
);

  localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'(INT8_MAX);
  localparam logic signed [IN_W:0] SAT_LO = (IN_W+1)'(INT8_MIN);

  // One guard bit so the rounding add can never wrap.
  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] shr;

  assign ext = (IN_W+1)'(sum_in);

  generate
    if (OUT_SHIFT > 0) begin : g_round
      localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) <<< (OUT_SHIFT - 1);
      assign shr = (ext + HALF) >>> OUT_SHIFT;
    end else begin : g_pass
      assign shr = ext;
    end
  endgenerate

  always_comb begin
    if (shr > SAT_HI) begin
      sat_out = INT8_MAX;
    end else if (shr < SAT_LO) begin
      sat_out = INT8_MIN;
    end else begin
      sat_out = shr[7:0];
    end
  end

endmodule

// File: rtl/dense2_bias_seq_ctrl.sv
// Dense-2 output sequencer: acc + scaled bias, requantize to int8, stream out, track argmax class.
// Latency: acc handshake at cycle N -> out_valid at N+2; one neuron per >=3 cycles.
// Backpressure: acc_ready only in WAIT_ACC; out_* held stable while out_ready is low.
// Ports: clk/rst_n, start/busy/done control, bias_addr/bias_data to the external bias ROM,
//        class_id/class_valid result, io = acc input and int8 output streams.
module dense2_bias_seq_ctrl
  import dense2_pkg::*;
#(
  parameter int BIAS_SHIFT = 4,
  parameter int OUT_SHIFT  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        bias_addr,
  input  logic signed [BIAS_W-1:0] bias_data,
  output logic [ADDR_W-1:0]        class_id,
  output logic                     class_valid,
  dense2_bias_seq_ctrl_if.master   io
);

  localparam int                SUM_W    = ACC_W + BIAS_SHIFT + 2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OUT - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDR_W-1:0]        idx;
  logic signed [7:0]        max_q;
  logic signed [7:0]        out_q;
  logic [ADDR_W-1:0]        out_idx_q;
  logic                     out_last_q;
  logic signed [SUM_W-1:0]  sum_q;
  logic signed [SUM_W-1:0]  sum_nxt;
  logic signed [7:0]        sat;

  // Bias is sign-extended before the shift so negative biases scale correctly.
  assign sum_nxt = SUM_W'(io.acc_data) + (SUM_W'(bias_data) <<< BIAS_SHIFT);

  dense_requant_sat #(
    .IN_W      (SUM_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_requant (
    .sum_in  (sum_q),
    .sat_out (sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = (state != IDLE);
    done         = (state == FIN);
    class_valid  = (state == FIN);
    io.acc_ready = (state == WAIT_ACC);
    io.out_valid = (state == OUT);
    case (state)
      IDLE:     if (start) state_nxt = WAIT_ACC;
      WAIT_ACC: if (io.acc_valid) state_nxt = CALC;
      CALC:     state_nxt = OUT;
      OUT:      if (io.out_ready) state_nxt = (idx == LAST_IDX) ? FIN : WAIT_ACC;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      max_q      <= INT8_MIN;
      class_id   <= '0;
      sum_q      <= '0;
      out_q      <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= '0;
            max_q    <= INT8_MIN;
            class_id <= '0;
          end
        end
        WAIT_ACC: begin
          if (io.acc_valid) sum_q <= sum_nxt;
        end
        CALC: begin
          out_q      <= sat;
          out_idx_q  <= idx;
          out_last_q <= (idx == LAST_IDX);
        end
        OUT: begin
          if (io.out_ready) begin
            // Strict compare: on a tie the earlier (lower) neuron keeps the class.
            if (out_q > max_q) begin
              max_q    <= out_q;
              class_id <= idx;
            end
            if (idx != LAST_IDX) idx <= idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bias_addr   = idx;
  assign io.out_data = out_q;
  assign io.out_idx  = out_idx_q;
  assign io.out_last = out_last_q & (state == OUT);

endmodule

// File: tb/tb_dense2_bias_seq_ctrl.sv
// Two instances run in lockstep on shared stimulus: A with BIAS_SHIFT=4/OUT_SHIFT=6, B with 0/0.
// Expected outputs come from an arithmetic model of bias add, rounding, saturation and argmax.
module tb_dense2_bias_seq_ctrl;
  import dense2_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic acc_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [ACC_W-1:0] acc_data = '0;

  always #5 clk = ~clk;

  dense2_bias_seq_ctrl_if ifa ();
  dense2_bias_seq_ctrl_if ifb ();

  assign ifa.acc_valid = acc_valid;
  assign ifa.acc_data  = acc_data;
  assign ifa.out_ready = out_ready;
  assign ifb.acc_valid = acc_valid;
  assign ifb.acc_data  = acc_data;
  assign ifb.out_ready = out_ready;

  logic busy_a, done_a, cv_a, busy_b, done_b, cv_b;
  logic [ADDR_W-1:0] addr_a, addr_b, cid_a, cid_b;
  logic signed [BIAS_W-1:0] bias_a, bias_b;
  logic signed [BIAS_W-1:0] rom [NUM_OUT];

  always_comb begin
    bias_a = '0;
    bias_b = '0;
    if (int'(addr_a) < NUM_OUT) bias_a = rom[addr_a];
    if (int'(addr_b) < NUM_OUT) bias_b = rom[addr_b];
  end

  dense2_bias_seq_ctrl #(.BIAS_SHIFT(4), .OUT_SHIFT(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a), .done(done_a),
    .bias_addr(addr_a), .bias_data(bias_a), .class_id(cid_a), .class_valid(cv_a),
    .io(ifa.master)
  );

  dense2_bias_seq_ctrl #(.BIAS_SHIFT(0), .OUT_SHIFT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_b), .done(done_b),
    .bias_addr(addr_b), .bias_data(bias_b), .class_id(cid_b), .class_valid(cv_b),
    .io(ifb.master)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int hs_cnt_a = 0;

  always @(posedge clk) begin
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (ifa.out_valid && ifa.out_ready) hs_cnt_a++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model(input longint acc, input int bias, input int bs, input int os);
    longint s;
    s = acc + longint'(bias) * (longint'(1) << bs);
    if (os > 0) s = (s + (longint'(1) << (os - 1))) >>> os;
    if (s > 127) return 127;
    if (s < -128) return -128;
    return int'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, longint'({busy_a, done_a, cv_a, ifa.acc_ready, ifa.out_valid, ifa.out_last,
                                 ifa.out_data, ifa.out_idx, cid_a, addr_a}), 0);
    check({tag, "_b"}, longint'({busy_b, done_b, cv_b, ifb.acc_ready, ifb.out_valid, ifb.out_last,
                                 ifb.out_data, ifb.out_idx, cid_b, addr_b}), 0);
  endtask

  // One inference; reset_idx/restart_idx/stall_idx select the neuron for each disturbance (-1 none).
  task automatic run_inf(input longint accs[NUM_OUT], input int stall_idx, input int reset_idx,
                         input int restart_idx, input bit rnd);
    int ea[NUM_OUT];
    int eb[NUM_OUT];
    int ma, mb, ca, cb, d0a, d0b, h0, n, stall;
    ma = -128; mb = -128; ca = 0; cb = 0;
    d0a = done_cnt_a; d0b = done_cnt_b; h0 = hs_cnt_a;
    for (int i = 0; i < NUM_OUT; i++) begin
      ea[i] = model(accs[i], int'(rom[i]), 4, 6);
      eb[i] = model(accs[i], int'(rom[i]), 0, 0);
      if (ea[i] > ma) begin ma = ea[i]; ca = i; end
      if (eb[i] > mb) begin mb = eb[i]; cb = i; end
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", longint'({busy_a, busy_b}), 3);

    for (int i = 0; i < NUM_OUT; i++) begin
      n = 0;
      while (!ifa.acc_ready && n < 20) begin tick(); n++; end
      check("acc_ready_a", longint'(ifa.acc_ready), 1);
      check("acc_ready_b", longint'(ifb.acc_ready), 1);
      check("bias_addr_a", longint'(addr_a), i);
      check("bias_addr_b", longint'(addr_b), i);

      if (i == reset_idx) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("no_done_after_reset_a", longint'(done_cnt_a - d0a), 0);
        check("no_done_after_reset_b", longint'(done_cnt_b - d0b), 0);
        check("idle_after_reset", longint'({busy_a, busy_b}), 0);
        return;
      end

      if (i == restart_idx) start = 1'b1;
      if (rnd) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          start = 1'b0;
          check("acc_ready_hold", longint'(ifa.acc_ready), 1);
        end
      end

      acc_valid = 1'b1;
      acc_data  = ACC_W'(accs[i]);
      tick();
      acc_valid = 1'b0;
      start = 1'b0;
      check("calc_out_valid", longint'({ifa.out_valid, ifb.out_valid}), 0);
      check("calc_acc_ready", longint'({ifa.acc_ready, ifb.acc_ready}), 0);

      tick();
      check("out_valid_lat", longint'({ifa.out_valid, ifb.out_valid}), 3);
      check("out_data_a", longint'(ifa.out_data), ea[i]);
      check("out_data_b", longint'(ifb.out_data), eb[i]);
      check("out_idx_a", longint'(ifa.out_idx), i);
      check("out_idx_b", longint'(ifb.out_idx), i);
      check("out_last", longint'({ifa.out_last, ifb.out_last}), (i == NUM_OUT - 1) ? 3 : 0);

      stall = (i == stall_idx) ? 5 : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int k = 0; k < stall; k++) begin
        acc_valid = 1'b1;
        acc_data  = ACC_W'($urandom);
        tick();
        check("stall_data_a", longint'(ifa.out_data), ea[i]);
        check("stall_data_b", longint'(ifb.out_data), eb[i]);
        check("stall_idx", longint'(ifa.out_idx), i);
        check("stall_valid", longint'({ifa.out_valid, ifb.out_valid}), 3);
        check("stall_acc_ready", longint'({ifa.acc_ready, ifb.acc_ready}), 0);
      end
      acc_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    check("fin_done", longint'({done_a, cv_a, done_b, cv_b}), 15);
    check("class_id_a", longint'(cid_a), ca);
    check("class_id_b", longint'(cid_b), cb);
    tick();
    check("after_fin", longint'({done_a, cv_a, busy_a, done_b, cv_b, busy_b}), 0);
    check("class_hold_a", longint'(cid_a), ca);
    check("class_hold_b", longint'(cid_b), cb);
    check("done_pulses_a", longint'(done_cnt_a - d0a), 1);
    check("done_pulses_b", longint'(done_cnt_b - d0b), 1);
    check("out_count", longint'(hs_cnt_a - h0), NUM_OUT);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    longint accs[NUM_OUT];
    rom = '{8'sd34, -8'sd108, 8'sd75, 8'sd127, 8'sd8, 8'sd0, 8'sd127, -8'sd45, -8'sd75};

    #12;
    check_all_zero("reset_state");
    rst_n = 1'b1;
    tick();
    check_all_zero("idle_state");

    // All-zero accumulators: outputs are bias-only, tie 3/6 resolves to 3.
    for (int i = 0; i < NUM_OUT; i++) accs[i] = 0;
    run_inf(accs, -1, -1, -1, 1'b0);

    // Positive and negative saturation, plus a 5-cycle output stall on neuron 5.
    accs[3] = 1000;
    accs[1] = -200;
    run_inf(accs, 5, -1, -1, 1'b0);

    // Abort at neuron 4, then a clean run, then a run with a start pulse while busy.
    for (int i = 0; i < NUM_OUT; i++) accs[i] = longint'($urandom_range(0, 600)) - 300;
    run_inf(accs, -1, 4, -1, 1'b0);
    run_inf(accs, -1, -1, -1, 1'b0);
    run_inf(accs, -1, -1, 2, 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if ($urandom_range(0, 1) == 0)
          accs[i] = longint'($urandom_range(0, 600)) - 300;
        else
          accs[i] = longint'($urandom_range(0, 24000)) - 12000;
      end
      run_inf(accs, int'($urandom_range(0, 12)) - 3, -1, int'($urandom_range(0, 12)) - 3, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
